exc_vector_loader: RTL and testbench
====================================

EXC_VECTOR_LOADER -- requirements
Module: exc_vector_loader

Interface
REQ-001 Parameter MEM_LAT, default 2, memory read latency in cycles from stable address to valid mem_data_in; legal range 1..15.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 exc_req  input  3  exception requests: bit0 invalid opcode, bit1 arithmetic overflow, bit2 divide-by-zero.
REQ-005 pc_in  input  32  current PC value, already incremented by 4.
REQ-006 mem_data_in  input  32  memory read data; bits [7:0] hold the byte at the addressed location.
REQ-007 iord_sel  output  3  memory address mux select code.
REQ-008 epc_out  output  32  value to write into EPC.
REQ-009 epc_wr  output  1  EPC write enable, one-cycle pulse.
REQ-010 pc_out  output  32  new PC value (handler address).
REQ-011 pc_wr  output  1  PC write enable, one-cycle pulse.
REQ-012 cause_out  output  2  latched cause: 00 none, 01 opcode, 10 overflow, 11 divide-by-zero.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse, coincident with pc_wr.

Function
REQ-015 FSM states SHALL be IDLE, SAVE, WAIT, LOAD; all outputs registered or decoded from registered state only.
REQ-016 IDLE: if exc_req != 0 at a rising edge -> SAVE; latch cause, vector code and pc_in; else remain.
REQ-017 Priority when several exc_req bits set in same cycle: opcode > overflow > divide-by-zero; lower-priority requests dropped, not queued.
REQ-018 Vector code mapping: opcode -> iord_sel 3'b010 (address 253); overflow -> 3'b011 (254); divide-by-zero -> 3'b100 (255).
REQ-019 iord_sel SHALL be 3'b001 in IDLE, and hold the latched vector code in SAVE, WAIT and LOAD.
REQ-020 SAVE: one cycle; epc_wr=1, epc_out = latched pc_in - 4, modulo 2^32 (pc_in < 4 wraps, e.g. 0x00000002 -> 0xFFFFFFFE); -> WAIT.
REQ-021 WAIT: exactly MEM_LAT cycles counted by internal counter; at the edge ending the last WAIT cycle capture pc_out = {24'b0, mem_data_in[7:0]}; -> LOAD.
REQ-022 LOAD: one cycle; pc_wr=1, done=1; -> IDLE.
REQ-023 Latency: request sampled at end of cycle 0 -> epc_wr in cycle 1, pc_wr/done in cycle MEM_LAT+2, busy low again in cycle MEM_LAT+3.
REQ-024 exc_req SHALL be ignored while busy=1, including in the LOAD cycle; a request held high through LOAD is accepted in the following IDLE cycle.
REQ-025 epc_out, pc_out and cause_out SHALL hold their last values in IDLE until the next accepted exception overwrites them.
REQ-026 mem_data_in bits [31:8] SHALL have no effect on any output.
REQ-027 epc_wr and pc_wr SHALL never be high in the same cycle.

Reset
REQ-028 reset high at a rising edge -> state IDLE, counter 0, iord_sel=3'b001, epc_wr=0, pc_wr=0, done=0, busy=0, epc_out=0, pc_out=0, cause_out=00.
REQ-029 reset SHALL override any state, including mid-WAIT; no partial pc_wr or epc_wr pulse is issued after reset is sampled.
REQ-030 exc_req asserted in the same cycle as reset SHALL be discarded.

Verification
REQ-031 Overflow: exc_req=3'b010, pc_in=0x00000040, mem byte at 254 = 0x80, MEM_LAT=2 -> cycle1 epc_wr=1, epc_out=0x0000003C; iord_sel=3'b011 in cycles 1-4; cycle4 pc_wr=1, done=1, pc_out=0x00000080, cause_out=10.
REQ-032 Simultaneous: exc_req=3'b111 -> iord_sel=3'b010, cause_out=01, exactly one epc_wr and one pc_wr pulse; after return to IDLE with exc_req=0, no further activity.
REQ-033 Busy masking: divide-by-zero accepted, then exc_req=3'b001 pulsed in cycle 2 only -> single sequence with iord_sel=3'b100, cause_out=11, mem byte 0xA5 -> pc_out=0x000000A5.
REQ-034 Reset mid-WAIT: reset asserted in cycle 2 -> next cycle busy=0, iord_sel=3'b001, pc_out=0, no pc_wr pulse ever for that request.
REQ-035 Wrap and width: pc_in=0x00000000, mem_data_in=0xFFFFFF12, MEM_LAT=5 -> epc_out=0xFFFFFFFC, pc_wr in cycle 7, pc_out=0x00000012.
REQ-036 Back-to-back: exc_req held at 3'b100 continuously -> sequences repeat with exactly one IDLE cycle between consecutive LOAD and SAVE cycles.

Source files
------------

// File: rtl/exc_vector_loader.sv
// Exception vector loader: on an accepted exception, saves the return PC to
// EPC, reads the handler byte from the vector table, then loads it into PC.
module exc_vector_loader #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  exc_req,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic [2:0]  iord_sel,
    output logic [31:0] epc_out,
    output logic        epc_wr,
    output logic [31:0] pc_out,
    output logic        pc_wr,
    output logic [1:0]  cause_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_SAVE, S_WAIT, S_LOAD} state_t;

    localparam logic [2:0] SEL_PC  = 3'b001;
    localparam logic [2:0] SEL_OPC = 3'b010;
    localparam logic [2:0] SEL_OVF = 3'b011;
    localparam logic [2:0] SEL_DBZ = 3'b100;
    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [2:0]  code;
    logic        take;
    logic        wait_last;
    logic [2:0]  req_code;
    logic [1:0]  req_cause;

    assign take      = (state == S_IDLE) && (exc_req != 3'b000);
    assign wait_last = (cnt == CNT_LAST);

    // Fixed-priority encode of the request: opcode > overflow > divide-by-zero.
    always_comb begin
        req_code  = SEL_DBZ;
        req_cause = 2'b11;
        if (exc_req[0]) begin
            req_code  = SEL_OPC;
            req_cause = 2'b01;
        end else if (exc_req[1]) begin
            req_code  = SEL_OVF;
            req_cause = 2'b10;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; requests are only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (take) state_nxt = S_SAVE;
            S_SAVE: state_nxt = S_WAIT;
            S_WAIT: if (wait_last) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers: latch request context on acceptance, count the
    // memory latency, capture the handler byte on the last WAIT edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 4'd0;
            code      <= SEL_PC;
            epc_out   <= 32'd0;
            pc_out    <= 32'd0;
            cause_out <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= 4'd0;
                    if (take) begin
                        code      <= req_code;
                        cause_out <= req_cause;
                        epc_out   <= pc_in - 32'd4;
                    end
                end
                S_WAIT: begin
                    if (wait_last) begin
                        cnt    <= 4'd0;
                        pc_out <= {24'd0, mem_data_in[7:0]};
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: cnt <= 4'd0;
            endcase
        end
    end

    // Strobes and mux select decoded from registered state only.
    always_comb begin
        iord_sel = (state == S_IDLE) ? SEL_PC : code;
        epc_wr   = (state == S_SAVE);
        pc_wr    = (state == S_LOAD);
        done     = (state == S_LOAD);
        busy     = (state != S_IDLE);
    end

endmodule

// File: tb/tb_exc_vector_loader.sv
// Scoreboard bench for exc_vector_loader: stimulus pushes expected EPC/PC
// events, per-DUT monitors pop and compare on every epc_wr / pc_wr pulse.
module tb_exc_vector_loader;

    localparam int ML_A = 2;
    localparam int ML_B = 5;

    typedef struct {
        logic [31:0] val;
        logic [2:0]  sel;
        logic [1:0]  cause;
        bit          is_pc;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  exc_req, exc_req_b;
    logic [31:0] pc_in, pc_in_b;
    logic [31:0] mem_a, mem_b;
    logic [31:0] m253, m254, m255;

    logic [2:0]  iord_sel, iord_sel_b;
    logic [31:0] epc_out, epc_out_b, pc_out, pc_out_b;
    logic        epc_wr, epc_wr_b, pc_wr, pc_wr_b, busy, busy_b, done, done_b;
    logic [1:0]  cause_out, cause_out_b;

    ev_t qa[$];
    ev_t qb[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  epc_cyc_a = 0, last_pc_cyc_a = 0, last_gap_a = 0, npc_a = 0;
    int  epc_cyc_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Vector table model: combinational read keyed on the DUT's select.
    always_comb begin
        case (iord_sel)
            3'b010:  mem_a = m253;
            3'b011:  mem_a = m254;
            3'b100:  mem_a = m255;
            default: mem_a = 32'hDEADBE00;
        endcase
        mem_b = (iord_sel_b == 3'b010) ? 32'hFFFFFF12 : 32'hFFFFFF00;
    end

    exc_vector_loader #(.MEM_LAT(ML_A)) dut_a (
        .clk(clk), .reset(reset), .exc_req(exc_req), .pc_in(pc_in),
        .mem_data_in(mem_a), .iord_sel(iord_sel), .epc_out(epc_out),
        .epc_wr(epc_wr), .pc_out(pc_out), .pc_wr(pc_wr),
        .cause_out(cause_out), .busy(busy), .done(done)
    );

    exc_vector_loader #(.MEM_LAT(ML_B)) dut_b (
        .clk(clk), .reset(reset), .exc_req(exc_req_b), .pc_in(pc_in_b),
        .mem_data_in(mem_b), .iord_sel(iord_sel_b), .epc_out(epc_out_b),
        .epc_wr(epc_wr_b), .pc_out(pc_out_b), .pc_wr(pc_wr_b),
        .cause_out(cause_out_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic ev_t mk(input logic [31:0] v, input logic [2:0] s,
                               input logic [1:0] c, input bit p);
        ev_t e;
        e.val = v; e.sel = s; e.cause = c; e.is_pc = p;
        return e;
    endfunction

    // Monitor for the MEM_LAT=2 instance.
    always @(negedge clk) begin
        ev_t e;
        if (epc_wr || pc_wr) begin
            chk("a_wr_exclusive", {31'd0, epc_wr & pc_wr}, 32'd0);
            if (qa.size() == 0) begin
                chk("a_unexpected_pulse", {31'd0, pc_wr}, 32'hFFFFFFFF);
            end else begin
                e = qa.pop_front();
                chk("a_kind", {31'd0, pc_wr}, {31'd0, e.is_pc});
                chk(pc_wr ? "a_pc_out" : "a_epc_out", pc_wr ? pc_out : epc_out, e.val);
                chk("a_iord_sel", {29'd0, iord_sel}, {29'd0, e.sel});
                chk("a_cause", {30'd0, cause_out}, {30'd0, e.cause});
                if (pc_wr) begin
                    chk("a_done", {31'd0, done}, 32'd1);
                    chk("a_latency", cyc - epc_cyc_a, ML_A + 1);
                    last_pc_cyc_a = cyc;
                    npc_a++;
                end else begin
                    last_gap_a = cyc - last_pc_cyc_a;
                    epc_cyc_a  = cyc;
                end
            end
        end
    end

    // Monitor for the MEM_LAT=5 instance.
    always @(negedge clk) begin
        ev_t e;
        if (epc_wr_b || pc_wr_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_pulse", {31'd0, pc_wr_b}, 32'hFFFFFFFF);
            end else begin
                e = qb.pop_front();
                chk("b_kind", {31'd0, pc_wr_b}, {31'd0, e.is_pc});
                chk(pc_wr_b ? "b_pc_out" : "b_epc_out", pc_wr_b ? pc_out_b : epc_out_b, e.val);
                chk("b_iord_sel", {29'd0, iord_sel_b}, {29'd0, e.sel});
                if (pc_wr_b) chk("b_latency", cyc - epc_cyc_b, ML_B + 1);
                else         epc_cyc_b = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit hit;
        reset = 1'b1; exc_req = 3'b001; exc_req_b = 3'b001;
        pc_in = 32'h10; pc_in_b = 32'h0;
        m253 = 32'h0; m254 = 32'h0; m255 = 32'h0;
        repeat (3) step();
        // Reset state, with a request present during reset
        chk("rst_iord_sel", {29'd0, iord_sel}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_strobes", {29'd0, epc_wr, pc_wr, done}, 32'd0);
        chk("rst_epc_out", epc_out, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_cause", {30'd0, cause_out}, 32'd0);
        reset = 1'b0; exc_req = 3'b000; exc_req_b = 3'b000;
        step();
        chk("rst_req_discarded", {31'd0, busy}, 32'd0);
        chk("rst_req_discarded_b", {31'd0, busy_b}, 32'd0);

        // Overflow: pc 0x40, byte 0x80 at 254
        pc_in = 32'h40; m254 = 32'h12345680;
        qa.push_back(mk(32'h3C, 3'b011, 2'b10, 1'b0));
        qa.push_back(mk(32'h80, 3'b011, 2'b10, 1'b1));
        exc_req = 3'b010;
        step();
        exc_req = 3'b000;
        for (int c = 1; c <= 4; c++) begin
            chk("ovf_iord_sel", {29'd0, iord_sel}, 32'd3);
            step();
        end
        chk("ovf_idle_busy", {31'd0, busy}, 32'd0);
        chk("ovf_idle_iord", {29'd0, iord_sel}, 32'd1);
        repeat (3) step();
        chk("ovf_pc_hold", pc_out, 32'h80);
        chk("ovf_epc_hold", epc_out, 32'h3C);
        chk("ovf_cause_hold", {30'd0, cause_out}, 32'd2);

        // Simultaneous requests: opcode wins
        pc_in = 32'h100; m253 = 32'hFFFF0011;
        qa.push_back(mk(32'hFC, 3'b010, 2'b01, 1'b0));
        qa.push_back(mk(32'h11, 3'b010, 2'b01, 1'b1));
        exc_req = 3'b111;
        step();
        exc_req = 3'b000;
        repeat (8) step();
        chk("sim_idle", {31'd0, busy}, 32'd0);

        // Busy masking: dbz accepted, opcode pulse in cycle 2 ignored
        pc_in = 32'h2000; m255 = 32'h5A5A5AA5;
        qa.push_back(mk(32'h1FFC, 3'b100, 2'b11, 1'b0));
        qa.push_back(mk(32'hA5, 3'b100, 2'b11, 1'b1));
        exc_req = 3'b100;
        step();
        exc_req = 3'b000;
        step();
        exc_req = 3'b001;
        step();
        exc_req = 3'b000;
        repeat (7) step();
        chk("mask_idle", {31'd0, busy}, 32'd0);

        // Wrap: pc 0x2 -> epc 0xFFFFFFFE
        pc_in = 32'h2; m254 = 32'hFFFFFF03;
        qa.push_back(mk(32'hFFFFFFFE, 3'b011, 2'b10, 1'b0));
        qa.push_back(mk(32'h03, 3'b011, 2'b10, 1'b1));
        exc_req = 3'b010;
        step();
        exc_req = 3'b000;
        repeat (7) step();

        // Back-to-back: dbz held, two sequences, one IDLE cycle between
        pc_in = 32'h300; m255 = 32'h000000C4;
        for (int k = 0; k < 2; k++) begin
            qa.push_back(mk(32'h2FC, 3'b100, 2'b11, 1'b0));
            qa.push_back(mk(32'hC4, 3'b100, 2'b11, 1'b1));
        end
        begin
            int n0;
            n0 = npc_a;
            hit = 1'b0;
            exc_req = 3'b100;
            for (int w = 0; w < 40 && !hit; w++) begin
                @(negedge clk);
                if (npc_a >= n0 + 2) hit = 1'b1;
            end
            exc_req = 3'b000;
            chk("b2b_two_loads_seen", {31'd0, hit}, 32'd1);
        end
        chk("b2b_gap", last_gap_a, 32'd2);
        repeat (8) step();
        chk("b2b_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of WAIT: no pc_wr for this request
        pc_in = 32'h500; m253 = 32'h77;
        qa.push_back(mk(32'h4FC, 3'b010, 2'b01, 1'b0));
        exc_req = 3'b001;
        step();
        exc_req = 3'b000;
        step();
        reset = 1'b1;
        step();
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_iord", {29'd0, iord_sel}, 32'd1);
        chk("midrst_pc_out", pc_out, 32'd0);
        chk("midrst_epc_out", epc_out, 32'd0);
        chk("midrst_cause", {30'd0, cause_out}, 32'd0);
        reset = 1'b0;
        repeat (6) step();

        // MEM_LAT=5: pc 0 wraps, upper data bits ignored
        pc_in_b = 32'h0;
        qb.push_back(mk(32'hFFFFFFFC, 3'b010, 2'b01, 1'b0));
        qb.push_back(mk(32'h12, 3'b010, 2'b01, 1'b1));
        exc_req_b = 3'b001;
        step();
        exc_req_b = 3'b000;
        repeat (10) step();
        chk("b_idle", {31'd0, busy_b}, 32'd0);
        chk("b_pc_hold", pc_out_b, 32'h12);

        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
